// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector with arm/stop control,
// overlapping-match counting and auto-stop at a match limit.
module seq_detect_ctrl #(
  parameter int PAT_W = 6,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] match_limit,
  input  logic             start,
  input  logic             stop,
  input  logic             in,
  input  logic             in_valid,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] PMAX = LEN_W'(PAT_W);

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_cl;
  // oldest history bit is never compared, so only PAT_W-1 bits are kept
  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-1:0] hist_nx;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] lim_q;
  logic [PAT_W-1:0] mask;
  logic             out_q;
  logic             shift;
  logic             match;
  logic             arm;
  logic             cfg_ok;

  assign len_cl = (cfg_len == '0 || cfg_len > PMAX)
                ? PMAX : cfg_len;
  assign hist_nx = {hist_q, in};
  assign fill_nx = (fill_q == PMAX)
                 ? PMAX : fill_q + 1'b1;
  assign cnt_nx = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (LEN_W'(i) < len_q);
  end

  assign shift = (state == ARMED) && in_valid && !stop;
  assign match = shift && (fill_nx >= len_q)
              && ((hist_nx & mask) == (pat_q & mask));
  assign cfg_ok = (state == IDLE) && cfg_we;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && !stop)
          state_nx = ARMED;
      end
      ARMED: begin
        if (stop)
          state_nx = IDLE;
        else if (match && lim_q != '0 && cnt_nx == lim_q)
          state_nx = DONE;
      end
      DONE: begin
        if (stop)
          state_nx = IDLE;
        else if (start)
          state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign arm = (state != ARMED) && (state_nx == ARMED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pat_q  <= '0;
      len_q  <= PMAX;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      lim_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      state <= state_nx;
      out_q <= match;
      if (cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= len_cl;
      end
      if (arm) begin
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
        lim_q  <= match_limit;
      end else if (shift) begin
        hist_q <= hist_nx[PAT_W-2:0];
        fill_q <= fill_nx;
        if (match)
          cnt_q <= cnt_nx;
      end
    end
  end

  assign out       = out_q;
  assign busy      = (state == ARMED);
  assign done      = (state == DONE);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: per-scenario tasks compare
// {out,busy,done,match_cnt} against hand-computed vectors.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [5:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] match_limit;
  logic       start;
  logic       stop;
  logic       in;
  logic       in_valid;
  logic       out;
  logic       busy;
  logic       done;
  logic [7:0] match_cnt;

  int vectors = 0;
  int errs = 0;

  seq_detect_ctrl dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .match_limit(match_limit),
    .start(start),
    .stop(stop),
    .in(in),
    .in_valid(in_valid),
    .out(out),
    .busy(busy),
    .done(done),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [5:0] p,
                         input logic [2:0] l,
                         input logic [7:0] lim);
    stop = 1'b1;
    step();
    stop = 1'b0;
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    step();
    cfg_we = 1'b0;
    match_limit = lim;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b0;
    cfg_we = 0; cfg_pattern = 0; cfg_len = 0;
    match_limit = 0; start = 0; stop = 0;
    in = 0; in_valid = 0;
    step();
    step();
    got = {out, busy, done, match_cnt};
    vectors++;
    if (got !== 11'd0) begin
      errs++;
      $display("FAIL reset got %b exp %b", got, 11'd0);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in = 1'b1;
    step();
    in_valid = 1'b0;
    got = {out, busy, done, match_cnt};
    vectors++;
    if (got !== 11'd0) begin
      errs++;
      $display("FAIL reset_idle got %b exp %b", got, 11'd0);
    end
  endtask

  task automatic test_full_len();
    logic [5:0] bits = 6'b101011;
    logic [10:0] got, exp;
    arm_cfg(6'b101011, 3'd6, 8'd0);
    got = {out, busy, done, match_cnt};
    exp = {1'b0, 1'b1, 1'b0, 8'd0};
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL t1_armed got %b exp %b", got, exp);
    end
    in_valid = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      in = bits[i];
      step();
      exp = (i == 0) ? {1'b1, 1'b1, 1'b0, 8'd1}
                     : {1'b0, 1'b1, 1'b0, 8'd0};
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL t1_bit%0d got %b exp %b", 5 - i, got, exp);
      end
    end
    in_valid = 1'b0;
    step();
    got = {out, busy, done, match_cnt};
    exp = {1'b0, 1'b1, 1'b0, 8'd1};
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL t1_after got %b exp %b", got, exp);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] eo = 5'b00101;
    logic [7:0] ec [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    logic [10:0] got, exp;
    arm_cfg(6'b000101, 3'd3, 8'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = bits[4 - i];
      step();
      exp = {eo[4 - i], 1'b1, 1'b0, ec[i]};
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL t2_bit%0d got %b exp %b", i, got, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [6:0] vld = 7'b1010101;
    logic [6:0] eo = 7'b0000101;
    logic [7:0] ec [7] = '{8'd0, 8'd0, 8'd0, 8'd0,
                           8'd1, 8'd1, 8'd2};
    logic [10:0] got, exp;
    arm_cfg(6'b111000, 3'd3, 8'd0);
    in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = vld[6 - i];
      step();
      exp = {eo[6 - i], 1'b1, 1'b0, ec[i]};
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL t3_cyc%0d got %b exp %b", i, got, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_limit();
    logic [10:0] e [4];
    logic [10:0] got;
    e[0] = {1'b0, 1'b1, 1'b0, 8'd0};
    e[1] = {1'b1, 1'b1, 1'b0, 8'd1};
    e[2] = {1'b1, 1'b0, 1'b1, 8'd2};
    e[3] = {1'b0, 1'b0, 1'b1, 8'd2};
    arm_cfg(6'b000011, 3'd2, 8'd2);
    match_limit = 8'd0;
    in_valid = 1'b1;
    in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== e[i]) begin
        errs++;
        $display("FAIL t4_bit%0d got %b exp %b", i, got, e[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_cfg_lock();
    logic [2:0] bits = 3'b101;
    logic [10:0] got, exp;
    arm_cfg(6'b000101, 3'd3, 8'd0);
    cfg_we = 1'b1;
    cfg_pattern = 6'b000010;
    step();
    cfg_we = 1'b0;
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    got = {out, busy, done, match_cnt};
    exp = 11'd0;
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL t5_stop got %b exp %b", got, exp);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      in = bits[i];
      step();
    end
    in_valid = 1'b0;
    got = {out, busy, done, match_cnt};
    exp = {1'b1, 1'b1, 1'b0, 8'd1};
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL t5_pat got %b exp %b", got, exp);
    end
  endtask

  task automatic test_clamp();
    logic [10:0] got, exp;
    arm_cfg(6'b111111, 3'd7, 8'd0);
    in_valid = 1'b1;
    in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = (i == 5) ? {1'b1, 1'b1, 1'b0, 8'd1}
                     : {1'b0, 1'b1, 1'b0, 8'd0};
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL clamp_bit%0d got %b exp %b", i, got, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2:0] bits = 3'b101;
    logic [10:0] got, exp;
    arm_cfg(6'b000101, 3'd3, 8'd0);
    in_valid = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      in = bits[i];
      step();
    end
    in_valid = 1'b0;
    got = {out, busy, done, match_cnt};
    exp = {1'b1, 1'b1, 1'b0, 8'd1};
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL t6_pre got %b exp %b", got, exp);
    end
    #2;
    rst = 1'b0;
    #1;
    got = {out, busy, done, match_cnt};
    vectors++;
    if (got !== 11'd0) begin
      errs++;
      $display("FAIL t6_async got %b exp %b", got, 11'd0);
    end
    step();
    rst = 1'b1;
    in_valid = 1'b1;
    in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== 11'd0) begin
        errs++;
        $display("FAIL t6_idle%0d got %b exp %b", i, got, 11'd0);
      end
    end
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = (i == 5) ? {1'b1, 1'b1, 1'b0, 8'd1}
                     : {1'b0, 1'b1, 1'b0, 8'd0};
      got = {out, busy, done, match_cnt};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL t6_dflt%0d got %b exp %b", i, got, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_len();
    test_overlap();
    test_gaps();
    test_limit();
    test_cfg_lock();
    test_clamp();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
